print_uart_drain: RTL

//  PS-side consumer of the Print_sub print buffer.
//  - On a print request: reads the REG_NUMBER 32-bit words by address, serialises their bytes as 8N1 UART frames, then returns a finish pulse.
//  - Sits between the SOC print outputs (print_ps_en_o, print_ps_data_o) and the SOC print inputs (print_ps_data_addr_i, print_ps_finish_i).

---
 rtl/print_uart_drain.sv | 209 ++++++++++++++++++++
 1 files changed

// File: rtl/print_uart_drain.sv
// print_uart_drain: reads the print buffer word by word and sends each byte,
// little-endian, as an 8N1 UART frame, then pulses print_finish_o once.
module print_uart_drain #(
  parameter int REG_NUMBER  = 16,
  parameter int ADDR_W      = $clog2(REG_NUMBER) + 2,
  parameter int CLK_DIV     = 868,
  parameter bit STOP_ON_NUL = 1'b1
) (
  input  logic              clk_sys_i,
  input  logic              rst_sys_n_i,
  input  logic              print_en_i,
  input  logic [31:0]       print_data_i,
  output logic [ADDR_W-1:0] print_addr_o,
  output logic              print_finish_o,
  output logic              uart_tx_o,
  output logic              busy_o
);

  localparam int                CNT_W     = $clog2(CLK_DIV);
  localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(CLK_DIV - 1);
  localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(REG_NUMBER - 1);

  typedef enum logic [3:0] {
    ST_IDLE   = 4'd0,
    ST_ADDR   = 4'd1,
    ST_LOAD   = 4'd2,
    ST_BYTE   = 4'd3,
    ST_START  = 4'd4,
    ST_DATA   = 4'd5,
    ST_STOP   = 4'd6,
    ST_DONE   = 4'd7,
    ST_WAITLO = 4'd8
  } state_t;

  state_t            state_r, state_s;
  logic              en_d_r;
  logic [ADDR_W-1:0] addr_r, addr_s;
  logic [31:0]       word_r, word_s;
  logic [1:0]        idx_r, idx_s;
  logic [CNT_W-1:0]  cnt_r, cnt_s;
  logic [2:0]        bit_r, bit_s;
  logic              abort_r, abort_s;
  logic              tx_r, tx_s;
  logic              finish_r;
  logic              busy_r;
  logic [7:0]        byte_s;
  logic              bit_end_s;

  assign byte_s    = word_r[{idx_r, 3'b000} +: 8];
  assign bit_end_s = (cnt_r == CNT_LAST);

  // Next-state, datapath and next line-level logic
  always_comb begin
    state_s = state_r;
    addr_s  = addr_r;
    word_s  = word_r;
    idx_s   = idx_r;
    cnt_s   = cnt_r;
    bit_s   = bit_r;
    abort_s = abort_r;
    case (state_r)
      ST_IDLE: begin
        if (print_en_i && !en_d_r) begin
          state_s = ST_ADDR;
          addr_s  = '0;
          idx_s   = 2'd0;
          cnt_s   = '0;
          bit_s   = 3'd0;
          abort_s = 1'b0;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_ADDR: begin
        if (!print_en_i) begin
          state_s = ST_IDLE;
          addr_s  = '0;
        end else begin
          state_s = ST_LOAD;
        end
      end
      ST_LOAD: begin
        if (!print_en_i) begin
          state_s = ST_IDLE;
          addr_s  = '0;
        end else begin
          word_s  = print_data_i;
          idx_s   = 2'd0;
          state_s = ST_BYTE;
        end
      end
      ST_BYTE: begin
        if (!print_en_i) begin
          state_s = ST_IDLE;
          addr_s  = '0;
        end else if (STOP_ON_NUL && (byte_s == 8'h00)) begin
          state_s = ST_DONE;
        end else begin
          state_s = ST_START;
          cnt_s   = '0;
        end
      end
      ST_START: begin
        abort_s = abort_r | ~print_en_i;
        if (bit_end_s) begin
          cnt_s   = '0;
          bit_s   = 3'd0;
          state_s = ST_DATA;
        end else begin
          cnt_s = cnt_r + CNT_W'(1);
        end
      end
      ST_DATA: begin
        abort_s = abort_r | ~print_en_i;
        if (!bit_end_s) begin
          cnt_s = cnt_r + CNT_W'(1);
        end else if (bit_r == 3'd7) begin
          cnt_s   = '0;
          state_s = ST_STOP;
        end else begin
          cnt_s = '0;
          bit_s = bit_r + 3'd1;
        end
      end
      ST_STOP: begin
        // A request dropped mid-frame is only honoured once the stop bit is out.
        abort_s = abort_r | ~print_en_i;
        if (!bit_end_s) begin
          cnt_s = cnt_r + CNT_W'(1);
        end else if (abort_r || !print_en_i) begin
          cnt_s   = '0;
          addr_s  = '0;
          state_s = ST_IDLE;
        end else if (idx_r != 2'd3) begin
          cnt_s   = '0;
          idx_s   = idx_r + 2'd1;
          state_s = ST_BYTE;
        end else if (addr_r < ADDR_LAST) begin
          cnt_s   = '0;
          addr_s  = addr_r + ADDR_W'(1);
          state_s = ST_ADDR;
        end else begin
          cnt_s   = '0;
          state_s = ST_DONE;
        end
      end
      ST_DONE: begin
        state_s = ST_WAITLO;
      end
      ST_WAITLO: begin
        if (!print_en_i) begin
          state_s = ST_IDLE;
        end else begin
          state_s = ST_WAITLO;
        end
      end
      default: begin
        state_s = ST_IDLE;
        addr_s  = '0;
        cnt_s   = '0;
        bit_s   = 3'd0;
        idx_s   = 2'd0;
        abort_s = 1'b0;
      end
    endcase

    // Line level is derived from the state being entered so it lines up with it.
    case (state_s)
      ST_START: tx_s = 1'b0;
      ST_DATA:  tx_s = byte_s[bit_s];
      default:  tx_s = 1'b1;
    endcase
  end

  // State and output registers
  always_ff @(posedge clk_sys_i or negedge rst_sys_n_i) begin
    if (!rst_sys_n_i) begin
      state_r  <= ST_IDLE;
      en_d_r   <= 1'b1;  // a level already high at reset release is not an edge
      addr_r   <= '0;
      word_r   <= 32'h0000_0000;
      idx_r    <= 2'd0;
      cnt_r    <= '0;
      bit_r    <= 3'd0;
      abort_r  <= 1'b0;
      tx_r     <= 1'b1;
      finish_r <= 1'b0;
      busy_r   <= 1'b0;
    end else begin
      state_r  <= state_s;
      en_d_r   <= print_en_i;
      addr_r   <= addr_s;
      word_r   <= word_s;
      idx_r    <= idx_s;
      cnt_r    <= cnt_s;
      bit_r    <= bit_s;
      abort_r  <= abort_s;
      tx_r     <= tx_s;
      finish_r <= (state_s == ST_DONE);
      busy_r   <= (state_s != ST_IDLE);
    end
  end

  assign print_addr_o   = addr_r;
  assign print_finish_o = finish_r;
  assign uart_tx_o      = tx_r;
  assign busy_o         = busy_r;

endmodule
